// File: rtl/im_fetch_pkg.sv
// Shared widths, state encoding and line-buffer entry layout for the instruction fetch bridge.
// The PREF state exists only when IM_FETCH_PREFETCH_EN is defined.
package im_fetch_pkg;

    localparam int unsigned IM_AW = 10;
    localparam int unsigned IM_DW = 32;

`ifdef IM_FETCH_PREFETCH_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEMAND = 2'd1,
        ST_PREF   = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEMAND = 2'd1
    } fetch_state_e;
`endif

    typedef struct packed {
        logic             valid;
        logic [IM_AW-1:0] tag;
        logic [IM_DW-1:0] data;
    } line_entry_t;

    // Next sequential word address, wrapping 1023 -> 0.
    function automatic logic [IM_AW-1:0] next_addr(input logic [IM_AW-1:0] a);
        return a + IM_AW'(1);
    endfunction

endpackage

// File: rtl/im_line_buf.sv
// Single-entry instruction line buffer: write port, tag compare and combinational hit.
// Reset clears the valid bit.
module im_line_buf
    import im_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IM_AW-1:0] wr_tag_i,
    input  logic [IM_DW-1:0] wr_data_i,
    input  logic [IM_AW-1:0] rd_tag_i,
    output logic             hit_c,
    output logic [IM_DW-1:0] rd_data_c
);

    line_entry_t entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (wr_en_i) begin
            entry_q <= '{valid: 1'b1, tag: wr_tag_i, data: wr_data_i};
        end
    end

    assign hit_c     = entry_q.valid && (entry_q.tag == rd_tag_i);
    assign rd_data_c = entry_q.data;

endmodule

// File: rtl/im_fetch_bridge.sv
// Fetch bridge between the core instruction port and a req/ack instruction memory,
// with a one-entry line buffer. Next-line prefetch is built when IM_FETCH_PREFETCH_EN is defined.
module im_fetch_bridge
    import im_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             IM_enable,
    input  logic             IM_read,
    input  logic             IM_write,
    input  logic [IM_AW-1:0] IM_address,
    output logic [IM_DW-1:0] instruction,
    output logic             fetch_ready,
    output logic             fetch_err,
    output logic             mem_req,
    output logic [IM_AW-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [IM_DW-1:0] mem_rdata
);

    fetch_state_e     state_q, state_d;
    logic [IM_DW-1:0] instr_q, instr_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             req_q, req_d;
    logic [IM_AW-1:0] addr_q, addr_d;
    logic             dreq_c;
    logic             fill_c;
    logic             hit_c;
    logic [IM_DW-1:0] buf_data_c;
`ifdef IM_FETCH_PREFETCH_EN
    logic [IM_AW-1:0] pend_q, pend_d;
    logic             want_c;
    logic [IM_AW-1:0] want_addr_c;
`endif

    // Writes never start a memory access; they only raise the sticky error.
    assign dreq_c = IM_enable & IM_read & ~IM_write & ready_q;
    assign fill_c = req_q & mem_ack;

    im_line_buf u_line_buf (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (fill_c),
        .wr_tag_i  (addr_q),
        .wr_data_i (mem_rdata),
        .rd_tag_i  (IM_address),
        .hit_c     (hit_c),
        .rd_data_c (buf_data_c)
    );

`ifdef IM_FETCH_PREFETCH_EN
    // In PREF a demand is outstanding if one was latched earlier or arrives this edge.
    assign want_c      = ~ready_q | dreq_c;
    assign want_addr_c = ready_q ? IM_address : pend_q;
`endif

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ready_d = ready_q;
        req_d   = req_q;
        addr_d  = addr_q;
        err_d   = err_q | (IM_enable & IM_write);
`ifdef IM_FETCH_PREFETCH_EN
        pend_d  = pend_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (dreq_c) begin
                    if (hit_c) begin
                        instr_d = buf_data_c;
                    end else begin
                        state_d = ST_DEMAND;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = IM_address;
                    end
                end
            end
            ST_DEMAND: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    ready_d = 1'b1;
`ifdef IM_FETCH_PREFETCH_EN
                    state_d = ST_PREF;
                    req_d   = 1'b1;
                    addr_d  = next_addr(addr_q);
`else
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
`endif
                end
            end
`ifdef IM_FETCH_PREFETCH_EN
            ST_PREF: begin
                if (mem_ack) begin
                    if (!want_c) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end else if (want_addr_c == addr_q) begin
                        instr_d = mem_rdata;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_DEMAND;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = want_addr_c;
                    end
                end else if (dreq_c) begin
                    pend_d  = IM_address;
                    ready_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
`ifdef IM_FETCH_PREFETCH_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
`ifdef IM_FETCH_PREFETCH_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign instruction = instr_q;
    assign fetch_ready = ready_q;
    assign fetch_err   = err_q;
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;

endmodule

// File: tb/tb_im_fetch_bridge.sv
// Directed and randomized bench for im_fetch_bridge; memory contents come from a seeded word function
// and a transaction-level model tracks which address the line buffer holds.
module tb_im_fetch_bridge;

    logic        clk;
    logic        rst;
    logic        IM_enable;
    logic        IM_read;
    logic        IM_write;
    logic [9:0]  IM_address;
    logic [31:0] instruction;
    logic        fetch_ready;
    logic        fetch_err;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] seed;
    logic        mdl_valid;
    logic [9:0]  mdl_tag;
    logic [9:0]  last_a;
    logic [9:0]  a;

    im_fetch_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .IM_enable   (IM_enable),
        .IM_read     (IM_read),
        .IM_write    (IM_write),
        .IM_address  (IM_address),
        .instruction (instruction),
        .fetch_ready (fetch_ready),
        .fetch_err   (fetch_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_word(input logic [9:0] adr);
        return (32'(adr) * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Answer the request currently on the memory port after lat idle cycles.
    task automatic serve_one(input int lat);
        logic [9:0] a0;
        a0 = mem_addr;
        repeat (lat) begin
            @(negedge clk);
            chk("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, a0}));
        end
        mem_ack   = 1'b1;
        mem_rdata = ref_word(a0);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic rand_fetch(input logic [9:0] fa);
        logic hit;
`ifdef IM_FETCH_PREFETCH_EN
        logic [9:0] nxt;
`endif
        hit        = mdl_valid && (mdl_tag == fa);
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = fa;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        IM_address = 10'($urandom);
        chk("rnd_ready", 32'(fetch_ready), 32'(hit));
        chk("rnd_req", 32'(mem_req), 32'(!hit));
        if (!hit) begin
            chk("rnd_addr", 32'(mem_addr), 32'(fa));
            serve_one(int'($urandom_range(0, 3)));
            chk("rnd_done", 32'(fetch_ready), 32'd1);
`ifdef IM_FETCH_PREFETCH_EN
            nxt = fa + 10'd1;
            chk("rnd_pref_addr", 32'({mem_req, mem_addr}), 32'({1'b1, nxt}));
            serve_one(int'($urandom_range(0, 3)));
            mdl_tag = nxt;
`else
            mdl_tag = fa;
`endif
            mdl_valid = 1'b1;
        end
        chk("rnd_instr", instruction, ref_word(fa));
        chk("rnd_idle", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        IM_write   = 1'b0;
        IM_address = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        seed       = $urandom;
        mdl_valid  = 1'b0;
        mdl_tag    = '0;
        last_a     = '0;

        @(negedge clk);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cold miss at address 5, memory answers on the third cycle.
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd5;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("miss_req", 32'(mem_req), 32'd1);
        chk("miss_addr", 32'(mem_addr), 32'd5);
        chk("miss_busy", 32'(fetch_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("miss_hold", 32'({mem_req, mem_addr}), 32'h405);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("miss_instr", instruction, 32'hDEAD_BEEF);
        chk("miss_ready", 32'(fetch_ready), 32'd1);
`ifdef IM_FETCH_PREFETCH_EN
        chk("pref_req", 32'({mem_req, mem_addr}), 32'h406);
        serve_one(1);
        chk("pref_done", 32'(mem_req), 32'd0);
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd6;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("hit_instr", instruction, ref_word(10'd6));
`else
        chk("miss_req_drop", 32'(mem_req), 32'd0);
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd5;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("hit_instr", instruction, 32'hDEAD_BEEF);
`endif
        chk("hit_noreq", 32'(mem_req), 32'd0);
        chk("hit_ready", 32'(fetch_ready), 32'd1);

        // Illegal write: sticky error, no memory traffic.
        IM_enable  = 1'b1;
        IM_write   = 1'b1;
        IM_address = 10'd7;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_write   = 1'b0;
        chk("wr_err", 32'(fetch_err), 32'd1);
        chk("wr_noreq", 32'(mem_req), 32'd0);
        repeat (3) @(negedge clk);
        chk("wr_sticky", 32'({fetch_err, mem_req}), 32'h2);

        // Reset in the middle of a demand transfer, then a stray ack.
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd9;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("mid_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_ready", 32'(fetch_ready), 32'd1);
        chk("mid_rst_instr", instruction, 32'd0);
        chk("mid_rst_err", 32'(fetch_err), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("late_ack_instr", instruction, 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd5;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("inval_miss", 32'({mem_req, mem_addr}), 32'h405);
        serve_one(0);
        chk("inval_instr", instruction, ref_word(10'd5));
`ifdef IM_FETCH_PREFETCH_EN
        serve_one(0);

        // Wrap-around prefetch and a demand that matches it.
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd1023;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("wrap_req", 32'({mem_req, mem_addr}), 32'h7FF);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        mem_ack   = 1'b0;
        chk("wrap_instr", instruction, 32'hCAFE_0001);
        chk("wrap_pref", 32'({fetch_ready, mem_req, mem_addr}), 32'hC00);
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        IM_address = 10'd0;
        @(negedge clk);
        IM_enable  = 1'b0;
        IM_read    = 1'b0;
        chk("pend_state", 32'({fetch_ready, mem_req, mem_addr}), 32'h400);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("pend_instr", instruction, 32'h1234_5678);
        chk("pend_ready", 32'(fetch_ready), 32'd1);
        chk("pend_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("pend_noreq2", 32'(mem_req), 32'd0);
`endif

        // Randomized fetches against the buffer model, starting from a clean reset.
        rst = 1'b0;
        @(negedge clk);
        chk("rnd_rst", 32'({fetch_ready, mem_req, fetch_err}), 32'h4);
        rst       = 1'b1;
        mdl_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 10'd0;
                1:       a = 10'd1023;
                2:       a = last_a;
                3:       a = last_a + 10'd1;
                default: a = 10'($urandom);
            endcase
            rand_fetch(a);
            last_a = a;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
